// File: rtl/matrix_op_dispatcher.sv
`default_nettype none
// ============================================================================
// matrix_op_dispatcher
// Runs one matrix op at a time on a selected unit and muxes that unit onto the
// shared BRAM port. Optional watchdog: define MATRIX_DISPATCH_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module matrix_op_dispatcher #(
    parameter int ELEMENT_WIDTH  = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int NUM_UNITS      = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [1:0]                         cmd_op,
    input  logic [3:0]                         cmd_dim_m,
    input  logic [3:0]                         cmd_dim_n,
    input  logic [ADDR_WIDTH-1:0]              cmd_addr_a,
    input  logic [ADDR_WIDTH-1:0]              cmd_addr_b,
    input  logic [ADDR_WIDTH-1:0]              cmd_addr_res,
    output logic                               busy,
    output logic                               resp_valid,
    output logic [1:0]                         resp_err,
    output logic [NUM_UNITS-1:0]               unit_start,
    input  logic [NUM_UNITS-1:0]               unit_done,
    output logic [3:0]                         unit_dim_m,
    output logic [3:0]                         unit_dim_n,
    output logic [ADDR_WIDTH-1:0]              unit_addr_op1,
    output logic [ADDR_WIDTH-1:0]              unit_addr_op2,
    output logic [ADDR_WIDTH-1:0]              unit_addr_res,
    input  logic [NUM_UNITS-1:0]               unit_rd_en,
    input  logic [NUM_UNITS-1:0]               unit_wr_en,
    input  logic [NUM_UNITS*ADDR_WIDTH-1:0]    unit_rd_addr,
    input  logic [NUM_UNITS*ADDR_WIDTH-1:0]    unit_wr_addr,
    input  logic [NUM_UNITS*ELEMENT_WIDTH-1:0] unit_wr_data,
    output logic                               mem_rd_en,
    output logic                               mem_wr_en,
    output logic [ADDR_WIDTH-1:0]              mem_rd_addr,
    output logic [ADDR_WIDTH-1:0]              mem_wr_addr,
    output logic [ELEMENT_WIDTH-1:0]           mem_wr_data
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    // The unit index comes from a 2-bit opcode and the watchdog counter is 16 bits.
    if (NUM_UNITS < 1 || NUM_UNITS > 4 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536)
    begin : g_param_check
        $error("matrix_op_dispatcher: NUM_UNITS or TIMEOUT_CYCLES out of range");
    end

    logic [2:0]            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [3:0]            dim_m_q, dim_m_d, dim_n_q, dim_n_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_res_q, addr_res_d;
    logic [1:0]            grant_q, grant_d;
    logic                  grant_vld_q, grant_vld_d;
    logic [1:0]            err_q, err_d;
    logic [NUM_UNITS-1:0]  start_q, start_d;
`ifdef MATRIX_DISPATCH_TIMEOUT_EN
    logic [15:0]           cnt_q, cnt_d;
`endif

    logic [NUM_UNITS-1:0]  sel;
    logic [NUM_UNITS-1:0]  op_hot;
    logic                  done_g;

    always_comb begin
        sel    = '0;
        op_hot = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            sel[k]    = grant_vld_q && (32'(grant_q) == k);
            op_hot[k] = (32'(op_q) == k);
        end
        done_g = |(unit_done & sel);
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dim_m_d     = dim_m_q;
        dim_n_d     = dim_n_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        addr_res_d  = addr_res_q;
        grant_d     = grant_q;
        grant_vld_d = grant_vld_q;
        err_d       = err_q;
        start_d     = start_q;
`ifdef MATRIX_DISPATCH_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d       = cmd_op;
                    dim_m_d    = cmd_dim_m;
                    dim_n_d    = cmd_dim_n;
                    addr_a_d   = cmd_addr_a;
                    addr_b_d   = cmd_addr_b;
                    addr_res_d = cmd_addr_res;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                // An unknown opcode outranks a zero dimension.
                if (32'(op_q) >= 32'(NUM_UNITS)) begin
                    err_d   = 2'd1;
                    state_d = S_RESP;
                end else if (dim_m_q == 4'd0 || dim_n_q == 4'd0) begin
                    err_d   = 2'd2;
                    state_d = S_RESP;
                end else begin
                    err_d       = 2'd0;
                    grant_d     = op_q;
                    grant_vld_d = 1'b1;
                    start_d     = op_hot;
                    state_d     = S_START;
                end
            end
            S_START: begin
`ifdef MATRIX_DISPATCH_TIMEOUT_EN
                cnt_d   = 16'd0;
`endif
                state_d = S_RUN;
            end
            S_RUN: begin
                if (done_g) begin
                    start_d = '0;
                    state_d = S_RELEASE;
                end
`ifdef MATRIX_DISPATCH_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    start_d     = '0;
                    grant_vld_d = 1'b0;
                    err_d       = 2'd3;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            S_RELEASE: begin
                // Keep the unit on the BRAM port until it has dropped done.
                if (!done_g) begin
                    grant_vld_d = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                grant_vld_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                start_d     = '0;
                grant_vld_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            dim_m_q     <= '0;
            dim_n_q     <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            addr_res_q  <= '0;
            grant_q     <= '0;
            grant_vld_q <= 1'b0;
            err_q       <= '0;
            start_q     <= '0;
`ifdef MATRIX_DISPATCH_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dim_m_q     <= dim_m_d;
            dim_n_q     <= dim_n_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            addr_res_q  <= addr_res_d;
            grant_q     <= grant_d;
            grant_vld_q <= grant_vld_d;
            err_q       <= err_d;
            start_q     <= start_d;
`ifdef MATRIX_DISPATCH_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    always_comb begin
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (sel[k]) begin
                mem_rd_en   = unit_rd_en[k];
                mem_wr_en   = unit_wr_en[k];
                mem_rd_addr = unit_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wr_addr = unit_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wr_data = unit_wr_data[k*ELEMENT_WIDTH +: ELEMENT_WIDTH];
            end
        end
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign resp_valid    = (state_q == S_RESP);
    assign resp_err      = err_q;
    assign unit_start    = start_q;
    assign unit_dim_m    = dim_m_q;
    assign unit_dim_n    = dim_n_q;
    assign unit_addr_op1 = addr_a_q;
    assign unit_addr_op2 = addr_b_q;
    assign unit_addr_res = addr_res_q;

endmodule
`default_nettype wire

// File: doc/matrix_op_dispatcher.md
Name: matrix_op_dispatcher

Overview:
- Sequences one matrix operation at a time onto one of NUM_UNITS operation units (add, scalar-mul, transpose, mul, ...). All units share the start/done/BRAM-port protocol.
- Accepts a command over valid/ready, validates it, and drives the selected unit's start/dims/addresses.
- Muxes that unit's BRAM read/write port onto the single shared BRAM port until the unit finishes, then returns a one-cycle response.
- Sits between the top-level command decoder and the op units/BRAM; mem_rd_data is broadcast to units by the top and does not pass through this block.

Parameters:
ELEMENT_WIDTH, `ELEMENT_WIDTH (matrix_pkg.vh), matrix element width
ADDR_WIDTH, `BRAM_ADDR_WIDTH (matrix_pkg.vh), BRAM address width
NUM_UNITS, 4, number of op units; unit index = cmd_op
TIMEOUT_CYCLES, 4096, watchdog limit (used only with MATRIX_DISPATCH_TIMEOUT_EN)

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready
cmd_op  in  2  target unit index
cmd_dim_m, cmd_dim_n  in  4 each  rows, columns
cmd_addr_a, cmd_addr_b, cmd_addr_res  in  ADDR_WIDTH each  operand 1, operand 2, result base
busy  out  1  high in every state except IDLE
resp_valid  out  1  one-cycle completion pulse
resp_err  out  2  0 ok, 1 bad op, 2 zero dimension, 3 timeout; valid with resp_valid
unit_start  out  NUM_UNITS  one-hot start, level held
unit_done  in  NUM_UNITS  per-unit done
unit_dim_m, unit_dim_n  out  4 each  latched dims, broadcast to all units
unit_addr_op1, unit_addr_op2, unit_addr_res  out  ADDR_WIDTH each  latched addresses, broadcast
unit_rd_en, unit_wr_en  in  NUM_UNITS each  per-unit enables
unit_rd_addr, unit_wr_addr  in  NUM_UNITS*ADDR_WIDTH each  flattened; unit k at [k*ADDR_WIDTH +: ADDR_WIDTH]
unit_wr_data  in  NUM_UNITS*ELEMENT_WIDTH  flattened likewise
mem_rd_en, mem_wr_en  out  1 each  shared BRAM port enables
mem_rd_addr, mem_wr_addr  out  ADDR_WIDTH each  shared BRAM port addresses
mem_wr_data  out  ELEMENT_WIDTH  shared BRAM write data

Behaviour:
- Reset: state=IDLE; unit_start=0, resp_valid=0, resp_err=0, busy=0, grant invalid. Latched dims and addresses are 0. cmd_ready=1 after reset release.
- Reset mid-operation clears unit_start immediately (async) and returns to IDLE. Op units are reset by their own reset.
- Latched fields update only on accept and are stable until the next accept.
- States: IDLE, CHECK, START, RUN, RELEASE, RESP.
- IDLE: on accept (cycle T), latch all cmd fields → CHECK.
- CHECK (T+1): if cmd_op >= NUM_UNITS, set err=1 → RESP. Else if dim_m==0 or dim_n==0, set err=2 → RESP (op check has priority). Else set grant=cmd_op, err=0 → START.
- START (T+2): unit_start[grant] registered high (visible from T+2) → RUN.
- RUN: hold unit_start[grant] high. On unit_done[grant]==1, clear unit_start next edge → RELEASE. Done bits from other units are ignored.
- RELEASE: wait for unit_done[grant]==0 (unit back in idle) → RESP.
- RESP: resp_valid=1 for exactly this cycle with resp_err; grant invalidated → IDLE. Earliest error response is at T+2.
- Memory mux, combinational from the registered grant:
  - grant valid (START..RELEASE): mem_* = granted unit's signals.
  - otherwise: mem_rd_en=mem_wr_en=0, addresses/data 0.
  - Non-granted units' enables never reach BRAM.
- cmd_valid asserted while busy is not accepted; no queueing. The command must be held by the source.
- No arithmetic besides the watchdog counter; field widths pass through unchanged.

Optional Feature:
- Macro: MATRIX_DISPATCH_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to RUN and increments each RUN cycle. If it reaches TIMEOUT_CYCLES-1 without unit_done[grant]: clear unit_start, invalidate grant, go directly to RESP with err=3. RELEASE is skipped.
- Undefined: no counter; RUN waits indefinitely and err=3 is never produced.

Test Plan:
- Add, op=0, 2x3, a=0, b=16, res=32, unit model done after 40 cycles → unit_start[0] high from T+2 until one cycle after done; mem port mirrors unit 0 only; resp_valid one pulse with err=0; cmd_ready back to 1 the cycle after RESP.
- cmd_op=3 with NUM_UNITS=3 → no unit_start, resp_valid at T+2 with err=1. Then dim_n=0, op=1 → err=2.
- Unit 1 granted while unit 2 drives rd_en=1, rd_addr=0x55 → mem_rd_en/addr follow unit 1 only; in IDLE mem_rd_en=mem_wr_en=0.
- cmd_valid held during RUN → cmd_ready=0, no second latch. The held command is accepted the cycle after RESP.
- rst pulsed during RUN → unit_start=0, busy=0, resp_valid=0 asynchronously; a new command afterwards completes normally.
- With MATRIX_DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=64, unit never done → resp err=3 after 64 RUN cycles, unit_start low. Without the macro → still busy after 10000 cycles.
